instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage sitting between the program counter/RAM read port and the decode/register-bank/ALU datapath. It owns the 8-bit program counter and drives the RAM instruction address (`pcinstruct`). It captures the returned word into the instruction register (`fetch`), whose fields drive the downstream decoders, muxes and ALU. It holds the current instruction while the memory controller owns the bus for an LDR/STR, and accepts branch redirects with a one-slot pending buffer.

## Interface

Parameters:
- `ADDR_W`, 8: program counter width.
- `DATA_W`, 32: instruction width.
- `RESET_PC`, 0: PC value after reset.
- `NOP`, 32'h0000_0000: word driven on `fetch` after reset and in a branch bubble.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-low reset.
- `enable`  in  1  fetch enable; low = hold everything.
- `stall`  in  1  memory controller busy (LDR/STR in progress); hold PC and `fetch`.
- `branch_valid`  in  1  redirect request, single-cycle pulse.
- `branch_target`  in  ADDR_W  redirect address.
- `mem_rdata`  in  DATA_W  RAM instruction read data, combinational from `pcinstruct`.
- `pcinstruct`  out  32  RAM instruction address, `{24'b0, pc}`.
- `fetch`  out  DATA_W  instruction register. Fields: `[27:24]` opcode, `[22:19]` dest, `[18:15]` src1, `[14:11]` src2.
- `fetch_valid`  out  1  one-cycle pulse: `fetch` holds a newly captured instruction.
- `pc`  out  ADDR_W  current program counter.
- `instr_count`  out  8  number of instructions captured, wraps.
- `halted`  out  1  fetch halted (only with `FETCH_HALT_EN`).

## Operation

- States: IDLE, RUN, HOLD, HALT.
- IDLE: entered on reset. Moves to RUN on the first edge with `enable`=1. The first capture happens on the edge after that.
- RUN, each edge with `enable`=1 and `stall`=0:
  - `fetch` <= `mem_rdata`
  - `fetch_valid` <= 1
  - `pc` <= `pc`+1, wrapping 8'hFF -> 8'h00
  - `instr_count` +1, wrapping
- RUN -> HOLD when `stall`=1 or `enable`=0. In HOLD, `pc`, `fetch` and `instr_count` are frozen and `fetch_valid`=0. HOLD -> RUN on the first edge with `stall`=0 and `enable`=1; that edge performs a normal capture.
- Branch, taken in RUN with no stall:
  - `pc` <= `branch_target`
  - `fetch` <= `NOP`
  - `fetch_valid` <= 0 (the word read at the old PC is discarded)
  - `instr_count` unchanged
  - The target instruction is captured on the next edge.
- Branch arriving during HOLD, or in the same cycle as `stall`: target is stored in the pending slot (`pend_valid`=1). It is applied as a branch on the HOLD -> RUN edge instead of a sequential capture.
- A second branch while pending is set overwrites the target (last wins).
- Branches in IDLE and HALT are ignored.
- Priority: reset > `enable`=0 / `stall` > pending branch > new branch > sequential fetch.
- `pcinstruct` is always `{24'b0, pc}`, combinational from the register.

## Timing

- Reset (edge with `reset`=0): `pc`=`RESET_PC`, `fetch`=`NOP`, `fetch_valid`=0, `instr_count`=0, `halted`=0, pending slot cleared, state IDLE. Reset in any state, including mid-stall or with a branch pending, discards all in-flight state.
- Fetch latency: one cycle from `pc` to the matching word on `fetch`.
- Throughput: one instruction per clock in RUN.
- Branch penalty: exactly one NOP cycle.
- `stall` is sampled at the edge. An edge with `stall`=1 never advances `pc`, even on the cycle `stall` first rises.

## Configuration

- `FETCH_HALT_EN` defined:
  - A captured word with opcode `[27:24]`=4'hF moves the FSM to HALT on that same edge. The halt word is still presented with `fetch_valid`=1.
  - `pc` is not incremented past the halt word.
  - `halted`=1 from the next cycle.
  - Only reset leaves HALT.
- `FETCH_HALT_EN` undefined: opcode 4'hF is fetched like any other word, state HALT does not exist, and `halted` is tied 0.

## Test plan

- Sequential run: reset low 1 cycle, `enable`=1, RAM[n]=n+32'h100 -> `fetch`=32'h100, 32'h101, 32'h102 on consecutive cycles, `fetch_valid`=1 each cycle, `pc` 1,2,3, `instr_count`=3.
- Stall: assert `stall` 3 cycles while `pc`=5 -> `pc` stays 5, `fetch` holds RAM[4], `fetch_valid`=0 for 3 cycles; after release `fetch`=RAM[5].
- Branch vs stall: `branch_valid`=1, target 8'h40, in the same cycle as `stall`=1 for 2 cycles -> no PC change during stall; on release `fetch`=NOP and `pc`=8'h40; next cycle `fetch`=RAM[0x40].
- Wrap and reset: run from `pc`=8'hFE for 3 cycles -> `pc` 8'hFF, 8'h00, 8'h01. Assert `reset`=0 mid-run -> `pc`=0, `fetch`=0, `instr_count`=0, state IDLE.
- With `FETCH_HALT_EN`, RAM[3]=32'h0F00_0000 -> captured with `fetch_valid`=1, `halted`=1 next cycle, `pc`=3 thereafter, and `branch_valid` is ignored.

Source files
------------

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - fetch stage bus: control, RAM read port and instruction register outputs
interface instr_fetch_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              enable;
  logic              stall;
  logic              branch_valid;
  logic [ADDR_W-1:0] branch_target;
  logic [DATA_W-1:0] mem_rdata;
  logic [31:0]       pcinstruct;
  logic [DATA_W-1:0] fetch;
  logic              fetch_valid;
  logic [ADDR_W-1:0] pc;
  logic [7:0]        instr_count;
  logic              halted;

  modport slave (
    input  enable, stall, branch_valid, branch_target, mem_rdata,
    output pcinstruct, fetch, fetch_valid, pc, instr_count, halted
  );

  modport master (
    output enable, stall, branch_valid, branch_target, mem_rdata,
    input  pcinstruct, fetch, fetch_valid, pc, instr_count, halted
  );
endinterface

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage: PC, instruction register, stall hold, pending branch slot
// Optional opcode-F halt enabled by defining FETCH_HALT_EN.
module instr_fetch #(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [DATA_W-1:0] NOP      = '0
) (
  input logic           clk,
  input logic           reset,
  instr_fetch_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HOLD
`ifdef FETCH_HALT_EN
    , S_HALT
`endif
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_fetch;
  logic              r_fetch_valid;
  logic [7:0]        r_count;
  logic              r_pend_valid;
  logic [ADDR_W-1:0] r_pend_target;

  logic              w_go;
  logic              w_adv;
  logic              w_capture;
  logic              w_redirect;
  logic              w_store_pend;
  logic [ADDR_W-1:0] w_redirect_target;
`ifdef FETCH_HALT_EN
  logic              w_halt_hit;
  logic              r_halted;
`endif

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (bus.enable) w_next_state = S_RUN;
      S_RUN, S_HOLD: begin
        if (w_go) begin
`ifdef FETCH_HALT_EN
          w_next_state = w_halt_hit ? S_HALT : S_RUN;
`else
          w_next_state = S_RUN;
`endif
        end else begin
          w_next_state = S_HOLD;
        end
      end
      default: w_next_state = r_state;
    endcase
  end

  // A pending redirect outranks a fresh branch_valid on the release edge.
  always_comb begin
    w_go              = bus.enable && !bus.stall;
    w_adv             = ((r_state == S_RUN) || (r_state == S_HOLD)) && w_go;
    w_redirect        = w_adv && (r_pend_valid || bus.branch_valid);
    w_capture         = w_adv && !r_pend_valid && !bus.branch_valid;
    w_store_pend      = ((r_state == S_RUN) || (r_state == S_HOLD)) && !w_go && bus.branch_valid;
    w_redirect_target = r_pend_valid ? r_pend_target : bus.branch_target;
`ifdef FETCH_HALT_EN
    w_halt_hit        = w_capture && (bus.mem_rdata[27:24] == 4'hF);
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc          <= RESET_PC;
      r_fetch       <= NOP;
      r_fetch_valid <= 1'b0;
      r_count       <= 8'd0;
      r_pend_valid  <= 1'b0;
      r_pend_target <= '0;
    end else begin
      r_fetch_valid <= 1'b0;
      if (w_capture) begin
        r_fetch       <= bus.mem_rdata;
        r_fetch_valid <= 1'b1;
        r_count       <= r_count + 8'd1;
`ifdef FETCH_HALT_EN
        if (!w_halt_hit) r_pc <= r_pc + ADDR_W'(1);
`else
        r_pc <= r_pc + ADDR_W'(1);
`endif
      end else if (w_redirect) begin
        r_pc    <= w_redirect_target;
        r_fetch <= NOP;
      end
      if (w_store_pend) begin
        r_pend_valid  <= 1'b1;
        r_pend_target <= bus.branch_target;
      end else if (w_adv) begin
        r_pend_valid  <= 1'b0;
      end
    end
  end

`ifdef FETCH_HALT_EN
  always_ff @(posedge clk) begin
    if (!reset) r_halted <= 1'b0;
    else        r_halted <= (r_state == S_HALT);
  end
  assign bus.halted = r_halted;
`else
  assign bus.halted = 1'b0;
`endif

  assign bus.pcinstruct  = {{(32-ADDR_W){1'b0}}, r_pc};
  assign bus.pc          = r_pc;
  assign bus.fetch       = r_fetch;
  assign bus.fetch_valid = r_fetch_valid;
  assign bus.instr_count = r_count;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed bench with cycle-level reference model for instr_fetch
module tb_instr_fetch;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
`ifdef FETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instr_fetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  logic [31:0] ram [256];
  assign bus.mem_rdata = ram[bus.pcinstruct[7:0]];

  instr_fetch #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(8'h00), .NOP(32'h0)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what a fetch stage must show after each edge.
  bit          m_known = 1'b0;
  bit          m_started, m_halt, m_halted_out, m_fv;
  logic [7:0]  m_pc, m_cnt;
  logic [31:0] m_fetch;
  logic [7:0]  m_pend [$];

  always @(posedge clk) begin
    if (!reset) begin
      m_known = 1'b1; m_started = 1'b0; m_halt = 1'b0; m_halted_out = 1'b0;
      m_fv = 1'b0; m_pc = 8'h00; m_cnt = 8'h00; m_fetch = 32'h0;
      m_pend.delete();
    end else begin
      m_halted_out = m_halt;
      m_fv = 1'b0;
      if (m_halt) begin
        m_fv = 1'b0;
      end else if (!m_started) begin
        m_started = bus.enable;
      end else if (!bus.enable || bus.stall) begin
        if (bus.branch_valid) begin
          m_pend.delete();
          m_pend.push_back(bus.branch_target);
        end
      end else if (m_pend.size() != 0) begin
        m_pc = m_pend.pop_front();
        m_fetch = 32'h0;
      end else if (bus.branch_valid) begin
        m_pc = bus.branch_target;
        m_fetch = 32'h0;
      end else begin
        m_fetch = ram[m_pc];
        m_fv = 1'b1;
        m_cnt = m_cnt + 8'd1;
        if (HALT_EN && m_fetch[27:24] == 4'hF) m_halt = 1'b1;
        else m_pc = m_pc + 8'd1;
      end
    end
    #1;
    if (m_known) begin
      chk("model_pc", {24'b0, bus.pc}, {24'b0, m_pc});
      chk("model_pcinstruct", bus.pcinstruct, {24'b0, m_pc});
      chk("model_fetch", bus.fetch, m_fetch);
      chk("model_fetch_valid", {31'b0, bus.fetch_valid}, {31'b0, m_fv});
      chk("model_count", {24'b0, bus.instr_count}, {24'b0, m_cnt});
      chk("model_halted", {31'b0, bus.halted}, {31'b0, m_halted_out});
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'h100 + i;
    reset = 1'b0;
    bus.enable = 1'b0; bus.stall = 1'b0;
    bus.branch_valid = 1'b0; bus.branch_target = 8'h00;
    step();
    chk("rst_pc", {24'b0, bus.pc}, 32'h0);
    chk("rst_fetch", bus.fetch, 32'h0);
    chk("rst_fv", {31'b0, bus.fetch_valid}, 32'h0);
    chk("rst_count", {24'b0, bus.instr_count}, 32'h0);
    chk("rst_halted", {31'b0, bus.halted}, 32'h0);

    reset = 1'b1; bus.enable = 1'b1;
    step();
    chk("idle_pc", {24'b0, bus.pc}, 32'h0);
    chk("idle_fv", {31'b0, bus.fetch_valid}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("seq_fetch", bus.fetch, 32'h100 + i);
      chk("seq_pc", {24'b0, bus.pc}, i + 1);
      chk("seq_fv", {31'b0, bus.fetch_valid}, 32'h1);
    end
    chk("seq_count", {24'b0, bus.instr_count}, 32'd3);

    step(); step();
    chk("pre_stall_pc", {24'b0, bus.pc}, 32'h5);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", {24'b0, bus.pc}, 32'h5);
      chk("stall_fetch", bus.fetch, 32'h104);
      chk("stall_fv", {31'b0, bus.fetch_valid}, 32'h0);
    end
    bus.stall = 1'b0;
    step();
    chk("unstall_fetch", bus.fetch, 32'h105);
    chk("unstall_pc", {24'b0, bus.pc}, 32'h6);

    bus.stall = 1'b1; bus.branch_valid = 1'b1; bus.branch_target = 8'h40;
    step();
    chk("bstall_pc0", {24'b0, bus.pc}, 32'h6);
    bus.branch_valid = 1'b0;
    step();
    chk("bstall_pc1", {24'b0, bus.pc}, 32'h6);
    bus.stall = 1'b0;
    step();
    chk("bstall_nop", bus.fetch, 32'h0);
    chk("bstall_pc", {24'b0, bus.pc}, 32'h40);
    chk("bstall_fv", {31'b0, bus.fetch_valid}, 32'h0);
    step();
    chk("btarget_fetch", bus.fetch, 32'h140);
    chk("btarget_count", {24'b0, bus.instr_count}, 32'd7);

    bus.stall = 1'b1; bus.branch_valid = 1'b1; bus.branch_target = 8'h10;
    step();
    bus.branch_target = 8'h20;
    step();
    bus.branch_valid = 1'b0; bus.stall = 1'b0;
    step();
    chk("lastwin_pc", {24'b0, bus.pc}, 32'h20);
    step();
    chk("lastwin_fetch", bus.fetch, 32'h120);

    bus.branch_valid = 1'b1; bus.branch_target = 8'hFE;
    step();
    chk("wrap_pc_fe", {24'b0, bus.pc}, 32'hFE);
    bus.branch_valid = 1'b0;
    step();
    chk("wrap_pc_ff", {24'b0, bus.pc}, 32'hFF);
    step();
    chk("wrap_pc_00", {24'b0, bus.pc}, 32'h00);
    chk("wrap_fetch", bus.fetch, 32'h1FF);
    step();
    chk("wrap_pc_01", {24'b0, bus.pc}, 32'h01);

    reset = 1'b0;
    step();
    chk("mid_rst_pc", {24'b0, bus.pc}, 32'h0);
    chk("mid_rst_fetch", bus.fetch, 32'h0);
    chk("mid_rst_count", {24'b0, bus.instr_count}, 32'h0);
    reset = 1'b1;
    step();
    chk("mid_rst_idle_fv", {31'b0, bus.fetch_valid}, 32'h0);

    ram[3] = 32'h0F00_0000;
    step(); step(); step(); step();
    chk("halt_word", bus.fetch, 32'h0F00_0000);
    chk("halt_word_fv", {31'b0, bus.fetch_valid}, 32'h1);
    chk("halt_word_pc", {24'b0, bus.pc}, HALT_EN ? 32'h3 : 32'h4);
    step();
    chk("halt_flag", {31'b0, bus.halted}, {31'b0, HALT_EN});
    chk("halt_pc", {24'b0, bus.pc}, HALT_EN ? 32'h3 : 32'h5);
    bus.branch_valid = 1'b1; bus.branch_target = 8'h80;
    step();
    bus.branch_valid = 1'b0;
    chk("halt_branch_pc", {24'b0, bus.pc}, HALT_EN ? 32'h3 : 32'h80);

    bus.enable = 1'b0;
    step(); step();
    chk("disable_fv", {31'b0, bus.fetch_valid}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
